imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 41 ++++
 rtl/imem_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle between the fetch/loader requesters, the arbiter and the instruction memory.
interface imem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;
  logic              busy;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err, busy
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err, busy
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester (fetch / loader) arbiter for a 1-cycle-latency single-port instruction memory.
// Define IMEM_ARB_RR_EN for round-robin arbitration; default is fixed loader priority.
module imem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;
  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  owner_e            own_q, own_d;
  lock_e             lock_q, lock_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
`ifdef IMEM_ARB_RR_EN
  logic              rr_q, rr_d;  // 1: fetch wins the next conflict
`endif

  logic              f_gnt, l_gnt, any_gnt, gnt_mis;
  logic [31:0]       gnt_addr;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q     <= OWN_NONE;
      lock_q    <= UNLOCKED;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
`ifdef IMEM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      own_q     <= own_d;
      lock_q    <= lock_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
`ifdef IMEM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      if (lock_q == LOCKED) begin
        l_gnt = bus.l_req;
      end else if (bus.l_req && bus.f_req) begin
`ifdef IMEM_ARB_RR_EN
        f_gnt = rr_q;
        l_gnt = !rr_q;
`else
        l_gnt = 1'b1;
`endif
      end else begin
        l_gnt = bus.l_req;
        f_gnt = bus.f_req;
      end
    end
  end

  always_comb begin
    any_gnt        = f_gnt || l_gnt;
    gnt_addr       = l_gnt ? bus.l_addr : bus.f_addr;
    gnt_mis        = any_gnt && (gnt_addr[1:0] != 2'b00);
    unused_addr_hi = ^gnt_addr[31:ADDR_W+2];

    bus.f_gnt     = f_gnt;
    bus.l_gnt     = l_gnt;
    bus.mem_en    = any_gnt && !gnt_mis;
    bus.mem_we    = bus.mem_en && l_gnt && bus.l_we;
    bus.mem_addr  = bus.mem_en ? gnt_addr[ADDR_W+1:2] : '0;
    bus.mem_wdata = l_gnt ? bus.l_wdata : '0;

    // Memory data is forwarded in the rvalid cycle and captured so it holds afterwards.
    rd_word   = mis_q ? '0 : bus.mem_rdata;
    f_rdata_d = (own_q == OWN_FETCH) ? rd_word : f_rdata_q;
    l_rdata_d = (own_q == OWN_LOAD)  ? rd_word : l_rdata_q;

    bus.f_rvalid = (own_q == OWN_FETCH);
    bus.l_rvalid = (own_q == OWN_LOAD);
    bus.f_rdata  = f_rdata_d;
    bus.l_rdata  = l_rdata_d;
    bus.busy     = (own_q != OWN_NONE);
    bus.err      = err_q;

    own_d = OWN_NONE;
    if (f_gnt) begin
      own_d = OWN_FETCH;
    end else if (l_gnt && !bus.l_we) begin
      own_d = OWN_LOAD;
    end
    mis_d = gnt_mis;
    err_d = gnt_mis;

    lock_d = lock_q;
    if (lock_q == LOCKED && !bus.l_lock) begin
      lock_d = UNLOCKED;
    end else if (l_gnt && bus.l_lock) begin
      lock_d = LOCKED;
    end

`ifdef IMEM_ARB_RR_EN
    rr_d = rr_q;
    if (l_gnt) begin
      rr_d = 1'b1;
    end else if (f_gnt) begin
      rr_d = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed scenarios followed by randomized traffic.
module tb_imem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(rst), .bus(bus));

  typedef struct {
    int          cyc;
    bit          is_f;
    bit          rd;
    bit          mis;
    logic [31:0] data;
  } resp_t;

  resp_t       sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ref_mem[256];
  logic [31:0] tb_mem[256];
  bit          m_locked = 1'b0;
  bit          m_last_l = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0020_8233;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Synchronous single-port memory, one cycle read latency.
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = init_word(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata <= tb_mem[bus.mem_addr];
      end
    end
  end

  task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                      input bit lr, input bit lwe, input bit llk,
                      input logic [31:0] la, input logic [31:0] lwd);
    bit          gf, gl, mis;
    logic [31:0] a;
    int          w;
    @(negedge clk);
    cyc++;
    rst = r;
    bus.f_req = fr;  bus.f_addr = fa;
    bus.l_req = lr;  bus.l_we = lwe;  bus.l_lock = llk;
    bus.l_addr = la; bus.l_wdata = lwd;
    #1;
    if (r) begin
      m_locked = 1'b0;
      m_last_l = 1'b0;
      sbq.delete();
      chk("rst_f_gnt",     32'(bus.f_gnt), 32'h0);
      chk("rst_l_gnt",     32'(bus.l_gnt), 32'h0);
      chk("rst_mem_en",    32'(bus.mem_en), 32'h0);
      chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
      chk("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      return;
    end
    gf = 1'b0;
    gl = 1'b0;
    if (m_locked) begin
      gl = lr;
    end else if (fr && lr) begin
`ifdef IMEM_ARB_RR_EN
      gl = !m_last_l;
      gf = m_last_l;
`else
      gl = 1'b1;
`endif
    end else begin
      gl = lr;
      gf = fr;
    end
    a   = gl ? la : fa;
    mis = (gl || gf) && (a[1:0] != 2'b00);
    w   = int'(a[9:2]);
    chk("f_gnt",  32'(bus.f_gnt), 32'(gf));
    chk("l_gnt",  32'(bus.l_gnt), 32'(gl));
    chk("mem_en", 32'(bus.mem_en), 32'((gl || gf) && !mis));
    if ((gl || gf) && !mis) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(w));
      chk("mem_we",   32'(bus.mem_we), 32'(gl && lwe));
      if (gl && lwe) chk("mem_wdata", bus.mem_wdata, lwd);
    end
    if (gl || gf) sbq.push_back('{cyc, gf, gf || !lwe, mis, mis ? 32'h0 : ref_mem[w]});
    if (gl && lwe && !mis) ref_mem[w] = lwd;
    if (m_locked && !llk) m_locked = 1'b0;
    else if (gl && llk)   m_locked = 1'b1;
    if (gl)      m_last_l = 1'b1;
    else if (gf) m_last_l = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: responses are due exactly one cycle after their grant.
  initial begin
    resp_t       e;
    bit          ef, el, ee;
    logic [31:0] last_f, last_l;
    last_f = '0;
    last_l = '0;
    forever begin
      @(negedge clk);
      #2;
      ef = 1'b0; el = 1'b0; ee = 1'b0;
      if (rst) begin
        last_f = '0;
        last_l = '0;
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc - 1) begin
          e = sbq.pop_front();
          chk("sb_stale", 32'(e.cyc), 32'(cyc - 1));
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
          e  = sbq.pop_front();
          ee = e.mis;
          if (e.rd) begin
            if (e.is_f) begin ef = 1'b1; last_f = e.data; end
            else        begin el = 1'b1; last_l = e.data; end
          end
        end
      end
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(ef));
      chk("l_rvalid", 32'(bus.l_rvalid), 32'(el));
      chk("err",      32'(bus.err), 32'(ee));
      chk("busy",     32'(bus.busy), 32'(ef || el));
      chk("f_rdata",  bus.f_rdata, last_f);
      chk("l_rdata",  bus.l_rdata, last_l);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
    bus.l_addr = '0;  bus.l_wdata = '0;

    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h8, 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    // Fetch of word 4 on the first edge after release
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    // Conflict: loader write wins, fetch follows
    step(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'h8, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    // Locked write burst with fetch held high, including a gap with l_req low
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1111_0000);
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h4, 32'h2222_0000);
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h8, 32'h3333_0000);
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h4,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    // Misaligned fetch and misaligned loader write
    step(1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'hFFFF_FFFF);
    idle();
    // Reset in the cycle after a fetch grant discards the read
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    // Both requesting continuously (reads)
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'(64 + i * 4), 32'h0);
    idle();
    // Randomized traffic, including high address bits and occasional lock
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(1)), raddr(),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(9) == 0), raddr(), $urandom);
    idle();
    idle();
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
